// File: rtl/fp_pkg.sv
// Shared single-precision floating-point definitions for the FP datapath
// (divider and multiplier units).
package fp_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } fp32_t;

  localparam int unsigned FP_BIAS    = 127;
  localparam logic [31:0] FP_QNAN    = 32'h7FC00000;
  localparam logic [7:0]  FP_EXP_MAX = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    DIVIDE,
    PACK
  } fp_state_e;

  typedef struct packed {
    logic is_zero;
    logic is_inf;
    logic is_nan;
  } fp_class_t;

  // Exponent 0 is treated as zero, so denormals are flushed.
  function automatic fp_class_t fp_classify(input fp32_t op);
    fp_class_t c;
    c.is_zero = (op.exp == 8'h00);
    c.is_inf  = (op.exp == FP_EXP_MAX) && (op.frac == '0);
    c.is_nan  = (op.exp == FP_EXP_MAX) && (op.frac != '0);
    return c;
  endfunction

endpackage

// File: rtl/mantissa_divider.sv
// Restoring iterative mantissa divider: one quotient bit per step.
// With 25 steps the quotient is floor(dividend * 2^24 / divisor).
module mantissa_divider #(
  parameter int unsigned ITER = 25
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            step,
  input  logic [23:0]     dividend,
  input  logic [23:0]     divisor,
  output logic [ITER-1:0] quot
);

  // Remainder stays below 2*divisor, so 25 bits are enough.
  logic [24:0]     rem_q, rem_d;
  logic [23:0]     dvs_q, dvs_d;
  logic [ITER-1:0] quot_q, quot_d;
  logic [23:0]     rem_sub;
  logic            qbit;

  // Load operands or perform one compare/subtract/shift iteration.
  always_comb begin
    rem_d  = rem_q;
    dvs_d  = dvs_q;
    quot_d = quot_q;
    qbit   = (rem_q >= {1'b0, dvs_q});
    // After a successful subtract the difference is below the divisor,
    // so the low 24 bits of the modular difference are exact.
    rem_sub = rem_q[23:0] - dvs_q;
    if (load) begin
      rem_d  = {1'b0, dividend};
      dvs_d  = divisor;
      quot_d = '0;
    end else if (step) begin
      rem_d  = qbit ? {rem_sub, 1'b0} : {rem_q[23:0], 1'b0};
      quot_d = {quot_q[ITER-2:0], qbit};
    end
  end

  // Divider state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      dvs_q  <= '0;
      quot_q <= '0;
    end else begin
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
      quot_q <= quot_d;
    end
  end

  assign quot = quot_q;

endmodule

// File: rtl/dividerunit.sv
// Sequential IEEE-754 single-precision divider, round-toward-zero.
// Normal operands take 26 cycles, special operands 1 cycle.
module dividerunit
  import fp_pkg::*;
#(
  parameter int unsigned WIDTH = 32,  // only 32 is supported
  parameter int unsigned ITER  = 25
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dataR
);

  localparam int unsigned CntW = $clog2(ITER);

  fp_state_e       state_q, state_d;
  logic            sign_q, sign_d;
  logic [7:0]      expa_q, expa_d;
  logic [7:0]      expb_q, expb_d;
  logic            special_q, special_d;
  logic [31:0]     spec_res_q, spec_res_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     result_q, result_d;
  logic            done_q, done_d;

  fp32_t           opa, opb;
  fp_class_t       ca, cb;
  logic            in_sign;
  logic            spec_hit;
  logic [31:0]     spec_val;

  logic            div_load, div_step;
  logic [ITER-1:0] quot;

  logic signed [9:0] exp_pack;
  logic [22:0]       mant_pack;
  logic [31:0]       norm_res;

  assign opa     = fp32_t'(dataA);
  assign opb     = fp32_t'(dataB);
  assign ca      = fp_classify(opa);
  assign cb      = fp_classify(opb);
  assign in_sign = opa.sign ^ opb.sign;

  // Special-operand detection in priority order (NaN-producing cases first).
  always_comb begin
    spec_hit = 1'b0;
    spec_val = '0;
    if (ca.is_nan || cb.is_nan || (ca.is_zero && cb.is_zero) || (ca.is_inf && cb.is_inf)) begin
      spec_hit = 1'b1;
      spec_val = FP_QNAN;
    end else if (ca.is_inf || cb.is_zero) begin
      spec_hit = 1'b1;
      spec_val = {in_sign, FP_EXP_MAX, 23'd0};
    end else if (ca.is_zero || cb.is_inf) begin
      spec_hit = 1'b1;
      spec_val = {in_sign, 31'd0};
    end
  end

  mantissa_divider #(
    .ITER (ITER)
  ) u_mantissa_divider (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (div_load),
    .step     (div_step),
    .dividend ({1'b1, opa.frac}),
    .divisor  ({1'b1, opb.frac}),
    .quot     (quot)
  );

  // Exponent adjust, normalisation and overflow/underflow saturation.
  always_comb begin
    exp_pack = $signed({2'b00, expa_q}) - $signed({2'b00, expb_q})
             + $signed(10'(FP_BIAS)) - $signed({9'd0, ~quot[24]});
    mant_pack = quot[24] ? quot[23:1] : quot[22:0];
    if (exp_pack >= 10'sd255) begin
      norm_res = {sign_q, FP_EXP_MAX, 23'd0};
    end else if (exp_pack <= 10'sd0) begin
      norm_res = {sign_q, 31'd0};
    end else begin
      norm_res = {sign_q, exp_pack[7:0], mant_pack};
    end
  end

  // Control FSM: accept, iterate, pack.
  always_comb begin
    state_d    = state_q;
    sign_d     = sign_q;
    expa_d     = expa_q;
    expb_d     = expb_q;
    special_d  = special_q;
    spec_res_d = spec_res_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    done_d     = 1'b0;
    div_load   = 1'b0;
    div_step   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          sign_d     = in_sign;
          expa_d     = opa.exp;
          expb_d     = opb.exp;
          special_d  = spec_hit;
          spec_res_d = spec_val;
          if (spec_hit) begin
            state_d = PACK;
          end else begin
            div_load = 1'b1;
            cnt_d    = CntW'(ITER - 1);
            state_d  = DIVIDE;
          end
        end
      end
      DIVIDE: begin
        div_step = 1'b1;
        if (cnt_q == '0) begin
          state_d = PACK;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      PACK: begin
        result_d = special_q ? spec_res_q : norm_res;
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sign_q     <= 1'b0;
      expa_q     <= '0;
      expb_q     <= '0;
      special_q  <= 1'b0;
      spec_res_q <= '0;
      cnt_q      <= '0;
      result_q   <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sign_q     <= sign_d;
      expa_q     <= expa_d;
      expb_q     <= expb_d;
      special_q  <= special_d;
      spec_res_q <= spec_res_d;
      cnt_q      <= cnt_d;
      result_q   <= result_d;
      done_q     <= done_d;
    end
  end

  assign busy  = (state_q != IDLE);
  assign done  = done_q;
  assign dataR = result_q;

endmodule

// File: tb/tb_dividerunit.sv
// Self-checking bench for dividerunit: vector table plus control corner cases,
// with a done-driven scoreboard.
module tb_dividerunit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] dataA;
  logic [31:0] dataB;
  logic        busy;
  logic        done;
  logic [31:0] dataR;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_q[$];

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    int          lat;
    string       name;
  } vec_t;

  vec_t vecs[$];

  dividerunit #(
    .WIDTH (32),
    .ITER  (25)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .dataA (dataA),
    .dataB (dataB),
    .busy  (busy),
    .done  (done),
    .dataR (dataR)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input bit ok, input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] r, input int lat, input string name);
    vec_t v;
    v.a = a; v.b = b; v.r = r; v.lat = lat; v.name = name;
    return v;
  endfunction

  // Scoreboard: every done pops one expected result.
  initial begin
    logic [31:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (done) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_done", dataR, 32'h0);
        end else begin
          e = exp_q.pop_front();
          chk(dataR === e, "dataR", dataR, e);
        end
      end
    end
  end

  // One operation; poke>0 pulses start that many cycles into the operation.
  task automatic run_op(input vec_t v, input int poke);
    int  n;
    bit  got;
    @(negedge clk);
    dataA = v.a;
    dataB = v.b;
    start = 1'b1;
    exp_q.push_back(v.r);
    @(posedge clk);
    #1;
    chk(busy === 1'b1, {v.name, " busy_after_accept"}, 32'(busy), 32'd1);
    @(negedge clk);
    start = 1'b0;
    dataA = $urandom;
    dataB = $urandom;
    n   = 0;
    got = 1'b0;
    while (!got && n < 60) begin
      @(posedge clk);
      #1;
      n++;
      if (start) start = 1'b0;
      if (done) got = 1'b1;
      else if (poke > 0 && n == poke) begin
        start = 1'b1;
        dataA = 32'h3F800000;
        dataB = 32'h40400000;
      end
    end
    if (!got) begin
      chk(1'b0, {v.name, " timeout"}, 32'(n), 32'(v.lat));
      if (exp_q.size() > 0) void'(exp_q.pop_back());
    end else begin
      chk(n == v.lat, {v.name, " latency"}, 32'(n), 32'(v.lat));
      chk(busy === 1'b0, {v.name, " busy_at_done"}, 32'(busy), 32'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    dataA = '0;
    dataB = '0;

    vecs.push_back(mk(32'h40C00000, 32'h40000000, 32'h40400000, 26, "6/2"));
    vecs.push_back(mk(32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 26, "1/3"));
    vecs.push_back(mk(32'hC1000000, 32'h3F000000, 32'hC1800000, 26, "-8/0.5"));
    vecs.push_back(mk(32'h40400000, 32'h3FC00000, 32'h40000000, 26, "3/1.5"));
    vecs.push_back(mk(32'h3F800000, 32'h00000000, 32'h7F800000, 1, "1/0"));
    vecs.push_back(mk(32'h00000000, 32'h00000000, 32'h7FC00000, 1, "0/0"));
    vecs.push_back(mk(32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1, "nan/1"));
    vecs.push_back(mk(32'h80000000, 32'h40A00000, 32'h80000000, 1, "-0/5"));
    vecs.push_back(mk(32'h7F800000, 32'h7F800000, 32'h7FC00000, 1, "inf/inf"));
    vecs.push_back(mk(32'h40000000, 32'hFF800000, 32'h80000000, 1, "2/-inf"));
    vecs.push_back(mk(32'h00400000, 32'h3F800000, 32'h00000000, 1, "denorm/1"));
    vecs.push_back(mk(32'h7F000000, 32'h00800000, 32'h7F800000, 26, "overflow"));
    vecs.push_back(mk(32'h00800000, 32'h7F000000, 32'h00000000, 26, "underflow"));

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    chk(busy === 1'b0, "reset busy", 32'(busy), 32'd0);
    chk(done === 1'b0, "reset done", 32'(done), 32'd0);
    chk(dataR === 32'h0, "reset dataR", dataR, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Consecutive calls start in the done cycle, exercising back-to-back accept.
    foreach (vecs[i]) run_op(vecs[i], 0);

    // start pulsed mid-DIVIDE must be ignored.
    run_op(vecs[0], 5);
    repeat (30) @(posedge clk);
    #1;
    chk(dataR === 32'h40400000, "ignored_start dataR", dataR, 32'h40400000);

    // Reset at iteration 10 aborts the operation without done.
    @(negedge clk);
    dataA = 32'h40C00000;
    dataB = 32'h40000000;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk(busy === 1'b0, "abort busy", 32'(busy), 32'd0);
    chk(done === 1'b0, "abort done", 32'(done), 32'd0);
    chk(dataR === 32'h0, "abort dataR", dataR, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    chk(busy === 1'b0, "post_abort busy", 32'(busy), 32'd0);
    chk(dataR === 32'h0, "post_abort dataR", dataR, 32'h0);
    run_op(vecs[1], 0);

    repeat (5) @(posedge clk);
    #1;
    chk(exp_q.size() == 0, "scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
